// File: rtl/uart_rx.sv
// Oversampling UART receiver: 1 start bit, DATA_WIDTH data bits sent LSB first,
// an optional parity bit and 1 stop bit. Each bit is a 2-of-3 majority vote
// around the bit centre. Every error-free byte raises a one-cycle DATA_VALID.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4:0]            PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  RX_IN,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_nxt;
  logic [4:0]            p_q;
  logic                  par_en_q, par_typ_q;
  logic [4:0]            edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic                  s0, s1;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_err;
  // Cleared by a line break; a new start bit is accepted only after the
  // line has been seen high again.
  logic                  armed;

  logic [4:0] half;
  logic       is_s0, is_s1, is_dec, is_end, maj, par_exp;
  logic       start_frame, good, brk;

  assign half    = p_q >> 1;
  assign is_s0   = (edge_cnt == half - 5'd1);
  assign is_s1   = (edge_cnt == half);
  assign is_dec  = (edge_cnt == half + 5'd1);
  assign is_end  = (edge_cnt == p_q - 5'd1);
  // The third vote is the live line value on the decision edge.
  assign maj     = (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);
  assign par_exp = par_typ_q ? ~^shreg : ^shreg;

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic and frame events
  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    good        = 1'b0;
    brk         = 1'b0;
    case (state)
      IDLE: begin
        if (!RX_IN && armed) begin
          state_nxt   = START;
          start_frame = 1'b1;
        end
      end
      START: begin
        if (is_dec && maj) state_nxt = IDLE;
        else if (is_end)   state_nxt = DATA;
      end
      DATA: begin
        if (is_end && bit_cnt == BW'(DATA_WIDTH - 1))
          state_nxt = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (is_end) state_nxt = STOP;
      end
      STOP: begin
        // Leave on the decision edge so a start bit can follow at once. The
        // exit at the end of the bit only matters for out-of-range prescales
        // whose decision point falls past the end of the bit.
        if (is_dec) begin
          state_nxt = IDLE;
          good      = maj & ~par_err;
          brk       = ~maj;
        end else if (is_end) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit timing, sampling, deserialisation and configuration capture
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt  <= '0;
      bit_cnt   <= '0;
      s0        <= 1'b1;
      s1        <= 1'b1;
      shreg     <= '0;
      par_err   <= 1'b0;
      p_q       <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      armed     <= 1'b0;
    end else begin
      if (state == IDLE || state_nxt == IDLE) edge_cnt <= '0;
      else if (is_end)                        edge_cnt <= '0;
      else                                    edge_cnt <= edge_cnt + 5'd1;

      if (state != DATA) bit_cnt <= '0;
      else if (is_end)   bit_cnt <= bit_cnt + 1'b1;

      if (is_s0) s0 <= RX_IN;
      if (is_s1) s1 <= RX_IN;

      if (state == DATA && is_dec) shreg[bit_cnt] <= maj;

      if (start_frame) begin
        p_q       <= PRESCALE;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        par_err   <= 1'b0;
      end else if (state == PARITY && is_dec && maj != par_exp) begin
        par_err <= 1'b1;
      end

      if (brk)                        armed <= 1'b0;
      else if (state == IDLE && RX_IN) armed <= 1'b1;
    end
  end

  // Output byte and strobe, one cycle after the stop-bit decision
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
    end else begin
      DATA_VALID <= good;
      if (good) P_DATA <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives frames bit by bit and checks the strobe
// count and the received bytes against hand-computed values.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] PRESCALE;
  logic       PAR_EN, PAR_TYP, RX_IN;
  logic [7:0] P_DATA;
  logic       DATA_VALID;

  int errors = 0;
  int checks = 0;
  int nstrb  = 0;
  int base;
  logic [7:0] got_q[$];
  logic prev_vld = 1'b0;
  logic dbl = 1'b0;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .PRESCALE(PRESCALE), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .RX_IN(RX_IN), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID)
  );

  always #5 CLK = ~CLK;

  // Strobe monitor, sampled away from the active edge
  always @(negedge CLK) begin
    if (DATA_VALID) begin
      nstrb++;
      got_q.push_back(P_DATA);
      if (prev_vld) dbl = 1'b1;
    end
    prev_vld = DATA_VALID;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    cyc(n);
  endtask

  // One frame; config inputs are scrambled after the start is seen to prove
  // the receiver works from its latched copy.
  task automatic send(input logic [7:0] d, input int p, input logic pen,
                      input logic pbit, input logic stopb);
    logic pt;
    pt = PAR_TYP;
    PRESCALE = 5'(p);
    PAR_EN   = pen;
    RX_IN    = 1'b0;
    cyc(1);
    PRESCALE = 5'd5;
    PAR_EN   = ~pen;
    PAR_TYP  = ~pt;
    cyc(p - 1);
    for (int i = 0; i < 8; i++) begin
      RX_IN = d[i];
      cyc(p);
    end
    if (pen) begin
      RX_IN = pbit;
      cyc(p);
    end
    RX_IN = stopb;
    cyc(p);
    PRESCALE = 5'(p);
    PAR_EN   = pen;
    PAR_TYP  = pt;
  endtask

  initial begin
    RST = 1'b0; RX_IN = 1'b1; PRESCALE = 5'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    cyc(3);
    chk("rst_pdata", P_DATA, 8'h00);
    chk("rst_valid", DATA_VALID, 1'b0);
    RST = 1'b1;
    idle(50);
    chk("idle_high_nostrobe", nstrb, 0);

    // 1: P=8, no parity, 0x55
    base = nstrb;
    send(8'h55, 8, 1'b0, 1'b0, 1'b1); idle(20);
    chk("t1_count", nstrb - base, 1);
    chk("t1_data", got_q[$], 8'h55);
    chk("t1_pdata", P_DATA, 8'h55);

    // 2: P=16, even parity, 0xA3 has four ones -> parity bit 0
    base = nstrb; PAR_TYP = 1'b0;
    send(8'hA3, 16, 1'b1, 1'b0, 1'b1); idle(40);
    chk("t2_count", nstrb - base, 1);
    chk("t2_data", P_DATA, 8'hA3);

    // 3: odd parity expects 1, bit sent 0 -> rejected
    base = nstrb; PAR_TYP = 1'b1;
    send(8'hA3 ^ 8'h00, 16, 1'b1, 1'b0, 1'b1); idle(40);
    chk("t3_count", nstrb - base, 0);
    chk("t3_keep", P_DATA, 8'hA3);
    PAR_TYP = 1'b0;

    // 4: framing error on 0x3C, then a good 0x81
    base = nstrb;
    send(8'h3C, 8, 1'b0, 1'b0, 1'b0); idle(20);
    chk("t4_ferr_count", nstrb - base, 0);
    chk("t4_ferr_keep", P_DATA, 8'hA3);
    send(8'h81, 8, 1'b0, 1'b0, 1'b1); idle(20);
    chk("t4_good_count", nstrb - base, 1);
    chk("t4_good_data", P_DATA, 8'h81);

    // 5: 2-cycle glitch at P=16, then a valid frame
    base = nstrb; PRESCALE = 5'd16;
    RX_IN = 1'b0; cyc(2); idle(60);
    chk("t5_glitch_count", nstrb - base, 0);
    chk("t5_glitch_idle", dut.state, 3'd0);
    send(8'h5A, 16, 1'b0, 1'b0, 1'b1); idle(40);
    chk("t5_count", nstrb - base, 1);
    chk("t5_data", P_DATA, 8'h5A);

    // 6: back-to-back 0x12, 0x34 with no idle gap
    base = nstrb;
    send(8'h12, 8, 1'b0, 1'b0, 1'b1);
    send(8'h34, 8, 1'b0, 1'b0, 1'b1); idle(20);
    chk("t6_count", nstrb - base, 2);
    chk("t6_first", got_q[got_q.size()-2], 8'h12);
    chk("t6_second", got_q[got_q.size()-1], 8'h34);

    // Break: line held low for many frames -> no strobe, recovers after high
    base = nstrb; PRESCALE = 5'd8;
    RX_IN = 1'b0; cyc(300);
    chk("brk_count", nstrb - base, 0);
    chk("brk_idle", dut.state, 3'd0);
    idle(10);
    send(8'h0F, 8, 1'b0, 1'b0, 1'b1); idle(20);
    chk("brk_recover_count", nstrb - base, 1);
    chk("brk_recover_data", P_DATA, 8'h0F);

    // Reset mid-frame clears outputs at once; next frame decodes
    base = nstrb;
    RX_IN = 1'b0; cyc(8);
    RX_IN = 1'b1; cyc(20);
    RST = 1'b0; #1;
    chk("midrst_pdata", P_DATA, 8'h00);
    chk("midrst_valid", DATA_VALID, 1'b0);
    cyc(2); RST = 1'b1; idle(10);
    send(8'h66, 8, 1'b0, 1'b0, 1'b1); idle(20);
    chk("midrst_count", nstrb - base, 1);
    chk("midrst_data", P_DATA, 8'h66);

    chk("no_double_strobe", dbl, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
